// File: rtl/reram_seq_pkg.sv
// Shared types, packet field positions and pack/unpack helpers for the ReRAM command sequencer.
// Builds with RERAM_SEQ_VERIFY_EN defined add the program-verify states.
package reram_seq_pkg;

    localparam int CMD_OP_LSB   = 30;
    localparam int CMD_ROW_LSB  = 25;
    localparam int CMD_COL_LSB  = 20;
    localparam int CMD_DATA_LSB = 0;
    localparam int ADDR_W       = 5;
    localparam int DATA_W       = 8;
    localparam int CNT_W        = 8;

    typedef enum logic [1:0] {
        OP_PROG = 2'b00,
        OP_READ = 2'b01,
        OP_ILL  = 2'b10
    } op_e;

`ifdef RERAM_SEQ_VERIFY_EN
    typedef enum logic [2:0] {
        ST_IDLE, ST_SETUP, ST_PULSE, ST_RESP, ST_VSETUP, ST_VPULSE
    } state_e;
`else
    typedef enum logic [1:0] {
        ST_IDLE, ST_SETUP, ST_PULSE, ST_RESP
    } state_e;
`endif

    typedef struct packed {
        op_e               op;
        logic [ADDR_W-1:0] row;
        logic [ADDR_W-1:0] col;
        logic [DATA_W-1:0] data;
    } cmd_t;

    // Both 1x encodings collapse onto OP_ILL; reserved bits [19:8] are dropped.
    function automatic cmd_t unpack_cmd(input logic [31:0] pkt);
        cmd_t c;
        c.op   = pkt[CMD_OP_LSB+1] ? OP_ILL : op_e'(pkt[CMD_OP_LSB +: 2]);
        c.row  = pkt[CMD_ROW_LSB +: ADDR_W];
        c.col  = pkt[CMD_COL_LSB +: ADDR_W];
        c.data = pkt[CMD_DATA_LSB +: DATA_W];
        return c;
    endfunction

    function automatic logic [31:0] pack_rsp(input logic [1:0] tag, input logic [ADDR_W-1:0] row,
                                             input logic [ADDR_W-1:0] col, input logic [DATA_W-1:0] data);
        return {tag, row, col, 12'h000, data};
    endfunction

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/reram_pulse_timer.sv
// Loadable down-counter shared by the setup and pulse phases; done while the count is zero.
module reram_pulse_timer
    import reram_seq_pkg::*;
(
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             load_i,
    input  logic [CNT_W-1:0] load_val_i,
    output logic             done_o
);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i)
            cnt_d = load_val_i;
        else if (cnt_q != '0)
            cnt_d = cnt_q - 1'b1;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end

    assign done_o = (cnt_q == '0);

endmodule

// File: rtl/reram_cmd_sequencer.sv
// Pops command packets, sequences crossbar setup/pulse timing and returns read responses.
// Optional program-verify with retries is enabled by defining RERAM_SEQ_VERIFY_EN.
module reram_cmd_sequencer
    import reram_seq_pkg::*;
#(
    parameter int SETUP_CYCLES    = 1,
    parameter int WR_PULSE_CYCLES = 4,
    parameter int RD_PULSE_CYCLES = 2,
    parameter int MAX_RETRY       = 3
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic        cmd_valid_i,
    input  logic [31:0] cmd_data_i,
    output logic        cmd_ready_o,
    output logic        arr_en_o,
    output logic        arr_we_o,
    output logic [4:0]  arr_row_o,
    output logic [4:0]  arr_col_o,
    output logic [7:0]  arr_wdata_o,
    input  logic [7:0]  arr_rdata_i,
    output logic        rsp_valid_o,
    output logic [31:0] rsp_data_o,
    input  logic        rsp_ready_i,
    output logic        busy_o,
    output logic [7:0]  err_cnt_o
);

    if (SETUP_CYCLES < 1 || WR_PULSE_CYCLES < 1 || RD_PULSE_CYCLES < 1 || MAX_RETRY < 0 ||
        SETUP_CYCLES > 256 || WR_PULSE_CYCLES > 256 || RD_PULSE_CYCLES > 256) begin : g_param_chk
        $error("reram_cmd_sequencer: cycle parameters must lie in 1..256");
    end

    localparam logic [CNT_W-1:0] SETUP_LD = CNT_W'(SETUP_CYCLES - 1);
    localparam logic [CNT_W-1:0] WR_LD    = CNT_W'(WR_PULSE_CYCLES - 1);
    localparam logic [CNT_W-1:0] RD_LD    = CNT_W'(RD_PULSE_CYCLES - 1);

    state_e      state_q, state_d;
    logic [4:0]  row_q, row_d, col_q, col_d;
    logic [7:0]  wdata_q, wdata_d, err_q, err_d;
    logic        we_q, we_d, en_q, en_d, ready_q, ready_d, rspv_q, rspv_d, busy_q, busy_d;
    logic [31:0] rsp_q, rsp_d;
    logic        tmr_load, tmr_done;
    logic [CNT_W-1:0] tmr_val;
    cmd_t        cmd;
`ifdef RERAM_SEQ_VERIFY_EN
    logic [7:0]  retry_q, retry_d;
`endif

    assign cmd = unpack_cmd(cmd_data_i);

    reram_pulse_timer u_timer (
        .clk_i      (wb_clk_i),
        .rst_i      (wb_rst_i),
        .load_i     (tmr_load),
        .load_val_i (tmr_val),
        .done_o     (tmr_done)
    );

    always_comb begin
        state_d  = state_q;
        row_d    = row_q;
        col_d    = col_q;
        wdata_d  = wdata_q;
        we_d     = we_q;
        err_d    = err_q;
        rsp_d    = rsp_q;
        tmr_load = 1'b0;
        tmr_val  = SETUP_LD;
`ifdef RERAM_SEQ_VERIFY_EN
        retry_d  = retry_q;
`endif
        case (state_q)
            ST_IDLE: if (cmd_valid_i) begin
                if (cmd.op == OP_ILL) begin
                    err_d = sat_inc(err_q);
                end else begin
                    row_d    = cmd.row;
                    col_d    = cmd.col;
                    wdata_d  = cmd.data;
                    we_d     = (cmd.op == OP_PROG);
                    state_d  = ST_SETUP;
                    tmr_load = 1'b1;
`ifdef RERAM_SEQ_VERIFY_EN
                    retry_d  = '0;
`endif
                end
            end
            ST_SETUP: if (tmr_done) begin
                state_d  = ST_PULSE;
                tmr_load = 1'b1;
                tmr_val  = we_q ? WR_LD : RD_LD;
            end
            ST_PULSE: if (tmr_done) begin
                if (we_q) begin
`ifdef RERAM_SEQ_VERIFY_EN
                    state_d  = ST_VSETUP;
                    we_d     = 1'b0;
                    tmr_load = 1'b1;
`else
                    state_d  = ST_IDLE;
`endif
                end else begin
                    state_d = ST_RESP;
                    rsp_d   = pack_rsp(2'b01, row_q, col_q, arr_rdata_i);
                end
            end
            ST_RESP: if (rsp_ready_i) state_d = ST_IDLE;
`ifdef RERAM_SEQ_VERIFY_EN
            ST_VSETUP: if (tmr_done) begin
                state_d  = ST_VPULSE;
                tmr_load = 1'b1;
                tmr_val  = RD_LD;
            end
            ST_VPULSE: if (tmr_done) begin
                if (arr_rdata_i == wdata_q) begin
                    state_d = ST_IDLE;
                end else if (32'(retry_q) < MAX_RETRY) begin
                    retry_d  = retry_q + 8'd1;
                    we_d     = 1'b1;
                    state_d  = ST_SETUP;
                    tmr_load = 1'b1;
                end else begin
                    err_d   = sat_inc(err_q);
                    rsp_d   = pack_rsp(2'b11, row_q, col_q, arr_rdata_i);
                    state_d = ST_RESP;
                end
            end
`endif
            default: state_d = ST_IDLE;
        endcase
        // Outputs are registered from the next state so they line up with it.
        ready_d = (state_d == ST_IDLE);
        busy_d  = (state_d != ST_IDLE);
        rspv_d  = (state_d == ST_RESP);
`ifdef RERAM_SEQ_VERIFY_EN
        en_d    = (state_d == ST_PULSE) || (state_d == ST_VPULSE);
`else
        en_d    = (state_d == ST_PULSE);
`endif
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q <= ST_IDLE;
            row_q   <= '0;
            col_q   <= '0;
            wdata_q <= '0;
            we_q    <= 1'b0;
            en_q    <= 1'b0;
            ready_q <= 1'b1;
            rspv_q  <= 1'b0;
            rsp_q   <= '0;
            busy_q  <= 1'b0;
            err_q   <= '0;
`ifdef RERAM_SEQ_VERIFY_EN
            retry_q <= '0;
`endif
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
            col_q   <= col_d;
            wdata_q <= wdata_d;
            we_q    <= we_d;
            en_q    <= en_d;
            ready_q <= ready_d;
            rspv_q  <= rspv_d;
            rsp_q   <= rsp_d;
            busy_q  <= busy_d;
            err_q   <= err_d;
`ifdef RERAM_SEQ_VERIFY_EN
            retry_q <= retry_d;
`endif
        end
    end

    assign cmd_ready_o = ready_q;
    assign arr_en_o    = en_q;
    assign arr_we_o    = we_q;
    assign arr_row_o   = row_q;
    assign arr_col_o   = col_q;
    assign arr_wdata_o = wdata_q;
    assign rsp_valid_o = rspv_q;
    assign rsp_data_o  = rsp_q;
    assign busy_o      = busy_q;
    assign err_cnt_o   = err_q;

endmodule

// File: tb/tb_reram_cmd_sequencer.sv
// Bench for reram_cmd_sequencer (default build): directed table, random commands vs a
// transaction-level model, illegal-op saturation and reset during a program pulse.
module tb_reram_cmd_sequencer;

    localparam int S = 1, WP = 4, RP = 2;

    logic        clk = 1'b0, rst = 1'b1, cmd_valid = 1'b0, rsp_ready = 1'b0;
    logic [31:0] cmd_data = '0;
    logic [7:0]  arr_rdata = '0;
    logic        cmd_ready, arr_en, arr_we, rsp_valid, busy;
    logic [4:0]  arr_row, arr_col;
    logic [7:0]  arr_wdata, err_cnt;
    logic [31:0] rsp_data;

    int vec = 0, miss = 0, err_exp = 0;

    always #5 clk = ~clk;

    reram_cmd_sequencer dut (
        .wb_clk_i(clk), .wb_rst_i(rst), .cmd_valid_i(cmd_valid), .cmd_data_i(cmd_data),
        .cmd_ready_o(cmd_ready), .arr_en_o(arr_en), .arr_we_o(arr_we), .arr_row_o(arr_row),
        .arr_col_o(arr_col), .arr_wdata_o(arr_wdata), .arr_rdata_i(arr_rdata),
        .rsp_valid_o(rsp_valid), .rsp_data_o(rsp_data), .rsp_ready_i(rsp_ready),
        .busy_o(busy), .err_cnt_o(err_cnt)
    );

    typedef struct {
        logic [31:0] pkt;
        logic [7:0]  rd;
        int          bp;
        int          en;
        int          back;
        int          lat;
        logic [31:0] rsp;
        int          err;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vec++;
        if (act !== exp) begin
            miss++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one command and observe it until cmd_ready returns (or the cycle budget runs out).
    task automatic run_cmd(input logic [31:0] pkt, input logic [7:0] rd, input int bp,
                           output int en_cnt, output int lat, output logic [31:0] rsp,
                           output int back, output bit stable_ok, output bit hold_ok);
        int vcnt;
        bit got;
        en_cnt = 0; lat = -1; rsp = '0; back = -1; stable_ok = 1; hold_ok = 1; vcnt = 0; got = 0;
        cmd_valid = 1'b1; cmd_data = pkt; arr_rdata = rd; rsp_ready = 1'b0;
        tick();
        cmd_valid = 1'b0; cmd_data = $urandom;
        for (int k = 0; k < 100; k++) begin
            if (arr_en) begin
                en_cnt++;
                if (k < S || arr_row !== pkt[29:25] || arr_col !== pkt[24:20] ||
                    arr_wdata !== pkt[7:0] || arr_we !== (pkt[31:30] == 2'b00))
                    stable_ok = 0;
            end
            if (rsp_valid) begin
                if (!got) begin got = 1; lat = k; rsp = rsp_data; end
                else if (rsp_data !== rsp) hold_ok = 0;
                vcnt++;
            end
            rsp_ready = (vcnt > bp);
            if (cmd_ready) begin
                back = k;
                if (busy || rsp_valid) hold_ok = 0;
                break;
            end
            if (!busy) hold_ok = 0;
            tick();
        end
    endtask

    task automatic apply(input string name, input logic [31:0] pkt, input logic [7:0] rd, input int bp,
                         input int e_en, input int e_back, input int e_lat, input logic [31:0] e_rsp,
                         input int e_err);
        int en_cnt, lat, back;
        logic [31:0] rsp;
        bit stable_ok, hold_ok;
        run_cmd(pkt, rd, bp, en_cnt, lat, rsp, back, stable_ok, hold_ok);
        chk({name, " en_cycles"}, en_cnt, e_en);
        chk({name, " ready_back"}, back, e_back);
        chk({name, " rsp_latency"}, lat, e_lat);
        chk({name, " rsp_data"}, rsp, e_rsp);
        chk({name, " addr_stable"}, stable_ok, 1);
        chk({name, " busy_hold"}, hold_ok, 1);
        chk({name, " err_cnt"}, err_cnt, e_err);
    endtask

    // Transaction-level expectations straight from the command semantics.
    task automatic apply_model(input string name, input logic [31:0] pkt, input logic [7:0] rd, input int bp);
        logic [1:0] op;
        int e_en, e_back, e_lat;
        logic [31:0] e_rsp;
        op = pkt[31:30];
        e_en = 0; e_back = 0; e_lat = -1; e_rsp = '0;
        if (op == 2'b00) begin
            e_en = WP; e_back = S + WP;
        end else if (op == 2'b01) begin
            e_en = RP; e_lat = S + RP; e_back = S + RP + 1 + bp;
            e_rsp = {2'b01, pkt[29:25], pkt[24:20], 12'h000, rd};
        end else begin
            err_exp = (err_exp < 255) ? err_exp + 1 : 255;
        end
        apply(name, pkt, rd, bp, e_en, e_back, e_lat, e_rsp, err_exp);
    endtask

    vec_t tbl[6];

    initial begin
        int en_seen, busy_seen;
        tbl[0] = '{32'h4670_0000, 8'hA5,  0, RP, 4,  3, 32'h4670_00A5, 0};
        tbl[1] = '{32'h3E00_003C, 8'h00,  0, WP, 5, -1, 32'h0,         0};
        tbl[2] = '{32'h467A_BC00, 8'h5A, 10, RP, 14, 3, 32'h4670_005A, 0};
        tbl[3] = '{32'h8000_0000, 8'h00,  0, 0,  0, -1, 32'h0,         1};
        tbl[4] = '{32'hC123_4567, 8'h11,  0, 0,  0, -1, 32'h0,         2};
        tbl[5] = '{32'h7FF0_0000, 8'hFF,  2, RP, 6,  3, 32'h7FF0_00FF, 2};

        repeat (3) tick();
        rst = 1'b0;
        tick();
        chk("reset cmd_ready", cmd_ready, 1);
        chk("reset en_we_rspv_busy", {arr_en, arr_we, rsp_valid, busy}, 4'b0000);
        chk("reset row_col_wdata_err", {arr_row, arr_col, arr_wdata, err_cnt}, 26'h0);
        chk("reset rsp_data", rsp_data, 32'h0);

        for (int i = 0; i < 6; i++)
            apply($sformatf("tbl%0d", i), tbl[i].pkt, tbl[i].rd, tbl[i].bp, tbl[i].en,
                  tbl[i].back, tbl[i].lat, tbl[i].rsp, tbl[i].err);
        err_exp = 2;

        for (int i = 0; i < 40; i++)
            apply_model($sformatf("rnd%0d", i), $urandom, 8'($urandom), int'($urandom_range(0, 3)));

        // A stream of illegal commands, one accepted every cycle.
        en_seen = 0; busy_seen = 0;
        cmd_valid = 1'b1; cmd_data = 32'h8000_0000;
        for (int i = 0; i < 300; i++) begin
            tick();
            if (arr_en) en_seen++;
            if (busy || !cmd_ready) busy_seen++;
        end
        cmd_valid = 1'b0;
        tick();
        chk("sat err_cnt", err_cnt, 8'd255);
        chk("sat no_pulse", en_seen, 0);
        chk("sat never_busy", busy_seen, 0);

        // Reset asserted during the second program-pulse cycle.
        cmd_valid = 1'b1; cmd_data = 32'h1234_5699;
        tick();
        cmd_valid = 1'b0;
        tick();
        tick();
        chk("rst pulse_active", {arr_en, arr_we}, 2'b11);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rst en_busy_rspv", {arr_en, busy, rsp_valid}, 3'b000);
        chk("rst err_cnt", err_cnt, 8'd0);
        chk("rst cmd_ready", cmd_ready, 1);
        err_exp = 0;
        apply_model("post_rst_read", 32'h5690_0000, 8'h77, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
        $finish;
    end

endmodule
